mod_serial_reducer: RTL and testbench

- Sequential, parametrised successor to the fixed 6-in/8-out mod-241 chunk LUTs. Computes the residue of an IN_W-bit operand modulo MOD.
- Consumes the operand CHUNK_W bits per cycle, MSB-first, using a Horner recurrence. This replaces one combinational LUT per chunk position with a single reduction datapath.
- Sits between operand producers and the residue-domain arithmetic units.
- Uses valid/ready handshakes on both sides.

---
 rtl/mod_serial_reducer.sv | 125 ++++++++++++
 tb/tb_mod_serial_reducer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_serial_reducer.sv
// Serial residue reducer: folds an IN_W-bit operand into (operand mod MOD),
// CHUNK_W bits per cycle, MSB chunk first, via a Horner recurrence.
module mod_serial_reducer #(
  parameter int MOD     = 241,
  parameter int IN_W    = 300,
  parameter int CHUNK_W = 6,
  parameter int RES_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_res,
  output logic             busy
);

  localparam int NCHUNK = (IN_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W  = NCHUNK * CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int SUM_W  = RES_W + CHUNK_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  if (MOD < 2 || MOD >= (1 << RES_W)) begin : g_bad_mod
    $error("mod_serial_reducer: MOD must satisfy 2 <= MOD < 2**RES_W");
  end
  if (CHUNK_W < 1 || CHUNK_W > IN_W) begin : g_bad_chunk
    $error("mod_serial_reducer: CHUNK_W must satisfy 1 <= CHUNK_W <= IN_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // acc < MOD, so {acc, chunk} < MOD*2^CHUNK_W; subtracting MOD*2^k from the
  // largest k down leaves a value below MOD after the k=0 step.
  function automatic logic [RES_W-1:0] horner_step(input logic [RES_W-1:0]   acc_v,
                                                    input logic [CHUNK_W-1:0] chunk_v);
    logic [SUM_W-1:0] t;
    logic [SUM_W-1:0] m;
    t = {acc_v, chunk_v};
    for (int k = CHUNK_W; k >= 0; k--) begin
      m = SUM_W'(MOD) << k;
      if (t >= m) t = t - m;
    end
    return t[RES_W-1:0];
  endfunction

  state_t             state;
  logic [RES_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [PAD_W-1:0]   shreg;
  logic [CHUNK_W-1:0] chunk;
  logic [RES_W-1:0]   acc_next;
  logic               accept;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign chunk    = shreg[PAD_W-1 -: CHUNK_W];
  assign acc_next = horner_step(acc, chunk);

  // NOTE: the operand shift register carries no reset; it is always loaded on
  // the accept edge before any chunk of it is consumed.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= PAD_W'(in_data);
    end else if (state == RUN) begin
      shreg <= shreg << CHUNK_W;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every branch
  // reads the pre-edge values of acc, cnt and state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            out_res   <= acc_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Back-to-back operand skips IDLE entirely.
            if (in_valid) begin
              state <= RUN;
              acc   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_serial_reducer.sv
// Bench for mod_serial_reducer: directed and random operands at the default
// configuration and at MOD=13 / IN_W=20 / CHUNK_W=3, checked against a % model.
module tb_mod_serial_reducer;

  localparam int NA = 50;
  localparam int NB = 7;

  logic clk = 1'b0;
  logic rst;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [299:0] a_in_data;
  logic [7:0]   a_out_res;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [19:0]  b_in_data;
  logic [3:0]   b_out_res;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod_serial_reducer u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_res(a_out_res),
    .busy(a_busy)
  );

  mod_serial_reducer #(.MOD(13), .IN_W(20), .CHUNK_W(3), .RES_W(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_res(b_out_res),
    .busy(b_busy)
  );

  task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [299:0] rand300();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r[299:0];
  endfunction

  function automatic logic [299:0] ref_a(input logic [299:0] op);
    return op % 300'd241;
  endfunction

  function automatic logic [19:0] ref_b(input logic [19:0] op);
    return op % 20'd13;
  endfunction

  // ---------------- DUT A helpers ----------------
  task automatic a_start(input logic [299:0] op);
    a_in_data  = op;
    a_in_valid = 1'b1;
    for (int i = 0; i < 200 && !a_in_ready; i++) begin
      @(posedge clk); #1;
    end
    check("a_ready_before_accept", a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_data  = rand300();
    check("a_busy_after_accept", a_busy, 1);
    check("a_in_ready_in_run", a_in_ready, 0);
    check("a_out_valid_in_run", a_out_valid, 0);
  endtask

  task automatic a_finish(input logic [299:0] exp, input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!a_out_valid && n < NA + 10);
    check({tag, "_latency"}, n, NA);
    check({tag, "_valid"}, a_out_valid, 1);
    check({tag, "_res"}, a_out_res, exp);
    check({tag, "_busy_done"}, a_busy, 0);
  endtask

  task automatic a_drain();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    check("a_drain_out_valid", a_out_valid, 0);
    check("a_drain_in_ready", a_in_ready, 1);
    check("a_drain_busy", a_busy, 0);
  endtask

  // ---------------- DUT B helpers ----------------
  task automatic b_run(input logic [19:0] op, input string tag);
    int n = 0;
    b_in_data  = op;
    b_in_valid = 1'b1;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_in_data  = 20'($urandom);
    check({tag, "_busy"}, b_busy, 1);
    do begin
      @(posedge clk); #1;
      n++;
    end while (!b_out_valid && n < NB + 10);
    check({tag, "_latency"}, n, NB);
    check({tag, "_res"}, b_out_res, ref_b(op));
    @(posedge clk); #1;
    check({tag, "_drain"}, b_out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [299:0] op;
    logic [7:0]   held;
    int           seen;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", a_out_valid, 0);
    check("reset_out_res", a_out_res, 0);
    check("reset_busy", a_busy, 0);
    check("reset_in_ready", a_in_ready, 1);
    rst = 1'b0;

    // Directed operands with known residues.
    a_start(300'd0);     a_finish(300'd0,   "zero");    a_drain();
    a_start(300'd240);   a_finish(300'd240, "op240");   a_drain();
    a_start(300'd241);   a_finish(300'd0,   "op241");   a_drain();
    a_start(300'd63);    a_finish(300'd63,  "op63");    a_drain();
    a_start({300{1'b1}}); a_finish(300'd239, "all_ones"); a_drain();
    op = 300'd1 << 299;
    a_start(op);         a_finish(300'd120, "bit299");  a_drain();
    op = 300'd1 << 12;
    a_start(op);         a_finish(300'd240, "pow12");   a_drain();
    op = 300'd241 * 300'd123456789;
    a_start(op);         a_finish(300'd0,   "multiple"); a_drain();

    // Backpressure in DONE with a waiting operand, then back-to-back accept.
    a_out_ready = 1'b0;
    op = rand300();
    a_start(op);
    a_finish(ref_a(op), "bp_first");
    held = a_out_res;
    op = rand300();
    a_in_data  = op;
    a_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", a_out_valid, 1);
      check("bp_hold_res", a_out_res, held);
      check("bp_hold_in_ready", a_in_ready, 0);
    end
    a_out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", a_in_ready, 1);
    a_start(op);
    a_finish(ref_a(op), "bp_second");
    a_drain();

    // Reset in the middle of RUN discards the partial result.
    a_start(rand300());
    repeat (24) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_in_ready", a_in_ready, 1);
    seen = 0;
    for (int i = 0; i < NA + 5; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) seen++;
    end
    check("midrst_no_stale", seen, 0);
    a_start(300'd1000); a_finish(300'd36, "after_rst"); a_drain();

    // Random operands, default configuration, random consumer stall.
    for (int i = 0; i < 12; i++) begin
      op = rand300();
      if (i % 3 == 1) op = op >> $urandom_range(0, 290);
      a_out_ready = 1'($urandom_range(0, 1));
      a_start(op);
      a_finish(ref_a(op), "rand_a");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      a_drain();
    end

    // Small configuration: 7 chunks with one bit of MSB padding.
    b_run(20'd0, "b_zero");
    b_run(20'hFFFFF, "b_all_ones");
    b_run(20'd65000, "b_multiple");
    b_run(20'd12, "b_op12");
    for (int i = 0; i < 20; i++) b_run(20'($urandom), "b_rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
